// File: rtl/pe_ct_pkg.sv
// Shared types, Q-format constants and saturating helpers for the coordinated-turn PE.
// Word width and fraction bits live here so the multiplier and top agree on the format.
package pe_ct_pkg;

    localparam int W    = 32;
    localparam int FRAC = 16;

    localparam logic signed [W-1:0] SMAX   = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0] SMIN   = {1'b1, {(W-1){1'b0}}};
    localparam logic signed [W-1:0] ONE    = W'(1) << FRAC;
    localparam logic signed [W-1:0] K_1_6  = W'(((64'sd1 <<< FRAC) + 64'sd3) / 64'sd6);
    localparam logic signed [W-1:0] K_1_24 = W'(((64'sd1 <<< FRAC) + 64'sd12) / 64'sd24);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_SUM,
        ST_HOLD
    } state_e;

    // Op code names the destination slot; operands are selected from it in the top.
    typedef enum logic [3:0] {
        OP_A,       // w * T
        OP_A2,      // a * a
        OP_A3,      // a * a2
        OP_A3_6,    // a3 / 6
        OP_A2_6,    // a2 / 6
        OP_A3_24,   // a3 / 24
        OP_SW,      // T * (1 - a2/6)
        OP_CW,      // T * (a/2 - a3/24)
        OP_SW_XD,
        OP_CW_ED,
        OP_C_XD,
        OP_S_ED,
        OP_CW_XD,
        OP_SW_ED,
        OP_S_XD,
        OP_C_ED
    } op_e;

    typedef struct packed {
        logic signed [W-1:0] xi;
        logic signed [W-1:0] xi_dot;
        logic signed [W-1:0] eta;
        logic signed [W-1:0] eta_dot;
        logic signed [W-1:0] w;
    } vec_t;

    typedef struct packed {
        logic                sat;
        logic signed [W-1:0] val;
    } satw_t;

    function automatic satw_t sat_w(input logic signed [2*W-1:0] v);
        satw_t r;
        r.sat = 1'b0;
        r.val = v[W-1:0];
        if (v > (2*W)'(SMAX)) begin
            r.sat = 1'b1;
            r.val = SMAX;
        end else if (v < (2*W)'(SMIN)) begin
            r.sat = 1'b1;
            r.val = SMIN;
        end
        return r;
    endfunction

    function automatic satw_t sat_add(input logic signed [W-1:0] a,
                                      input logic signed [W-1:0] b,
                                      input logic                sub);
        satw_t             r;
        logic signed [W:0] s;
        s     = sub ? ((W+1)'(a) - (W+1)'(b)) : ((W+1)'(a) + (W+1)'(b));
        r.sat = (s[W] != s[W-1]);
        r.val = r.sat ? (s[W] ? SMIN : SMAX) : s[W-1:0];
        return r;
    endfunction

endpackage

// File: rtl/pe_ct_mul_sat.sv
// Signed W x W multiply, arithmetic shift right by FRAC, saturate back to W bits.
// Purely combinational; the caller registers the result. No handshake.
// Backpressure: none, operands are consumed every cycle they are presented.
module pe_ct_mul_sat
    import pe_ct_pkg::*;
(
    input  logic signed [W-1:0] a_i,
    input  logic signed [W-1:0] b_i,
    output logic signed [W-1:0] res_o,
    output logic                sat_o
);

    logic signed [2*W-1:0] prod;
    satw_t                 r;

    always_comb begin
        prod  = (2*W)'(a_i) * (2*W)'(b_i);
        r     = sat_w(prod >>> FRAC);
        res_o = r.val;
        sat_o = r.sat;
    end

endmodule

// File: rtl/pe_ct_predict.sv
// Coordinated-turn time update of one state vector using Taylor-series trig terms.
// Latency: result valid at the 18th clock counting the accept edge; one vector per 19 clk.
// Backpressure: in_ready only in IDLE; result held in HOLD until out_ready.
module pe_ct_predict
    import pe_ct_pkg::*;
#(
    parameter logic [W-1:0] T_S   = W'(32'h0001_0000),
    parameter logic [W-1:0] W_MAX = W'(32'h0000_8000)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [5*W-1:0] in_data,
    input  logic           in_valid,
    output logic           in_ready,
    output logic [5*W-1:0] out_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic           out_sat,
    output logic           range_err
);

    state_e              state_q, state_d;
    logic [3:0]          op_q;
    op_e                 op;
    vec_t                vec_q, out_q, res_vec;
    logic signed [W-1:0] tmp_q [16];
    logic                sat_q, rng_q;

    logic signed [W-1:0] mul_a, mul_b, mul_res;
    logic                mul_sat, aux_sat, sum_sat, rng_d;
    logic [W-1:0]        a_abs;
    satw_t               s_r, c_r, sw_r, cw_r;
    satw_t               t_xi, r_xi, r_xd, t_eta, r_eta, r_ed;

    assign op = op_e'(op_q);

    pe_ct_mul_sat u_mul (
        .a_i   (mul_a),
        .b_i   (mul_b),
        .res_o (mul_res),
        .sat_o (mul_sat)
    );

    // Series terms are formed from slots that stop changing once op 5 is done.
    always_comb begin
        s_r     = sat_add(tmp_q[OP_A], tmp_q[OP_A3_6], 1'b1);
        c_r     = sat_add(ONE, tmp_q[OP_A2] >>> 1, 1'b1);
        sw_r    = sat_add(ONE, tmp_q[OP_A2_6], 1'b1);
        cw_r    = sat_add(tmp_q[OP_A] >>> 1, tmp_q[OP_A3_24], 1'b1);
        mul_a   = '0;
        mul_b   = '0;
        aux_sat = 1'b0;
        case (op)
            OP_A:     begin mul_a = vec_q.w;         mul_b = T_S;            end
            OP_A2:    begin mul_a = tmp_q[OP_A];     mul_b = tmp_q[OP_A];    end
            OP_A3:    begin mul_a = tmp_q[OP_A];     mul_b = tmp_q[OP_A2];   end
            OP_A3_6:  begin mul_a = tmp_q[OP_A3];    mul_b = K_1_6;          end
            OP_A2_6:  begin mul_a = tmp_q[OP_A2];    mul_b = K_1_6;          end
            OP_A3_24: begin mul_a = tmp_q[OP_A3];    mul_b = K_1_24;         end
            OP_SW: begin
                mul_a   = T_S;
                mul_b   = sw_r.val;
                aux_sat = sw_r.sat | s_r.sat | c_r.sat;
            end
            OP_CW: begin
                mul_a   = T_S;
                mul_b   = cw_r.val;
                aux_sat = cw_r.sat;
            end
            OP_SW_XD: begin mul_a = tmp_q[OP_SW];    mul_b = vec_q.xi_dot;   end
            OP_CW_ED: begin mul_a = tmp_q[OP_CW];    mul_b = vec_q.eta_dot;  end
            OP_C_XD:  begin mul_a = c_r.val;         mul_b = vec_q.xi_dot;   end
            OP_S_ED:  begin mul_a = s_r.val;         mul_b = vec_q.eta_dot;  end
            OP_CW_XD: begin mul_a = tmp_q[OP_CW];    mul_b = vec_q.xi_dot;   end
            OP_SW_ED: begin mul_a = tmp_q[OP_SW];    mul_b = vec_q.eta_dot;  end
            OP_S_XD:  begin mul_a = s_r.val;         mul_b = vec_q.xi_dot;   end
            OP_C_ED:  begin mul_a = c_r.val;         mul_b = vec_q.eta_dot;  end
            default: ;
        endcase
    end

    // |MIN| is not representable, so it clamps to MAX and still trips the range check.
    always_comb begin
        a_abs = mul_res[W-1] ? ((mul_res == SMIN) ? SMAX : -mul_res) : mul_res;
        rng_d = (a_abs > W_MAX);
    end

    always_comb begin
        t_xi    = sat_add(vec_q.xi, tmp_q[OP_SW_XD], 1'b0);
        r_xi    = sat_add(t_xi.val, tmp_q[OP_CW_ED], 1'b1);
        r_xd    = sat_add(tmp_q[OP_C_XD], tmp_q[OP_S_ED], 1'b1);
        t_eta   = sat_add(vec_q.eta, tmp_q[OP_CW_XD], 1'b0);
        r_eta   = sat_add(t_eta.val, tmp_q[OP_SW_ED], 1'b0);
        r_ed    = sat_add(tmp_q[OP_S_XD], tmp_q[OP_C_ED], 1'b0);
        sum_sat = t_xi.sat | r_xi.sat | r_xd.sat | t_eta.sat | r_eta.sat | r_ed.sat;
        res_vec = '{xi: r_xi.val, xi_dot: r_xd.val, eta: r_eta.val,
                    eta_dot: r_ed.val, w: vec_q.w};
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = ST_CALC;
            end
            ST_CALC: if (op == OP_C_ED) state_d = ST_SUM;
            ST_SUM:  state_d = ST_HOLD;
            ST_HOLD: begin
                out_valid = 1'b1;
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            out_q   <= '0;
            sat_q   <= 1'b0;
            rng_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: if (in_valid) begin
                    op_q  <= '0;
                    sat_q <= 1'b0;
                    rng_q <= 1'b0;
                end
                ST_CALC: begin
                    op_q  <= op_q + 4'd1;
                    sat_q <= sat_q | mul_sat | aux_sat;
                    if (op == OP_A) rng_q <= rng_d;
                end
                ST_SUM: begin
                    out_q <= res_vec;
                    sat_q <= sat_q | sum_sat;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == ST_IDLE && in_valid) vec_q <= vec_t'(in_data);
        if (state_q == ST_CALC) tmp_q[op_q] <= mul_res;
    end

    assign out_data  = out_q;
    assign out_sat   = sat_q;
    assign range_err = rng_q;

endmodule

// File: tb/tb_pe_ct_predict.sv
// Directed bench for pe_ct_predict in Q16.16 with T_S = 1.0; expected values computed by hand.
module tb_pe_ct_predict;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic [5*W-1:0] in_data;
    logic           in_valid;
    logic           in_ready;
    logic [5*W-1:0] out_data;
    logic           out_valid;
    logic           out_ready;
    logic           out_sat;
    logic           range_err;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    pe_ct_predict dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sat   (out_sat),
        .range_err (range_err)
    );

    function automatic logic signed [W-1:0] fld(input logic [5*W-1:0] d, input int i);
        return d[(4-i)*W +: W];
    endfunction

    function automatic logic [5*W-1:0] mk(input logic [W-1:0] xi, xd, eta, ed, w);
        return {xi, xd, eta, ed, w};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp, input int tol);
        logic signed [63:0] d;
        d = obs - exp;
        if (d < 0) d = -d;
        n_chk++;
        assert ((d <= 64'(tol)) === 1'b1) n_pass++;
        else $error("FAIL %s: observed %0h, expected %0h (tol %0d)", tag, obs, exp, tol);
    endtask

    task automatic chk_out(input string t, input logic signed [W-1:0] exi, exd, eeta, eed, ew,
                           input int tol, input logic esat, input logic erng);
        chk({t, "_xi"},      fld(out_data, 0), exi,  tol);
        chk({t, "_xi_dot"},  fld(out_data, 1), exd,  tol);
        chk({t, "_eta"},     fld(out_data, 2), eeta, tol);
        chk({t, "_eta_dot"}, fld(out_data, 3), eed,  tol);
        chk({t, "_w"},       fld(out_data, 4), ew,   0);
        chk({t, "_sat"},     out_sat,          esat, 0);
        chk({t, "_range"},   range_err,        erng, 0);
    endtask

    // Returns with the accept edge just behind us; nw = cycles spent waiting for in_ready.
    task automatic send(input logic [5*W-1:0] v, output int nw);
        nw = 0;
        while (in_ready !== 1'b1 && nw < 50) begin
            step();
            nw++;
        end
        chk("send_in_ready", in_ready, 1, 0);
        in_data  = v;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    // lat = edges after the accept edge until out_valid is seen; 17 means the 18th clock.
    task automatic wait_out(output int lat);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            step();
            lat++;
        end
    endtask

    initial begin
        int             lat, nw, bad;
        logic [5*W-1:0] snap;
        logic [5*W-1:0] v1, v2, v4, v6a, v6b, vmin;

        v1   = mk(32'h0, 32'h0002_0000, 32'h0, 32'h0, 32'h0);
        v2   = mk(32'h0, 32'h0001_0000, 32'h0, 32'h0, 32'h0000_1999);
        v4   = mk(32'h7D00_0000, 32'h03E8_0000, 32'h0, 32'h0, 32'h0);
        v6a  = mk(32'h0, 32'h0001_0000, 32'h0, 32'h0, 32'h0000_C000);
        v6b  = mk(32'h0, 32'h0001_0000, 32'h0, 32'h0, 32'h0000_6666);
        vmin = mk(32'h0, 32'h0001_0000, 32'h0, 32'h0, 32'h8000_0000);

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready",  in_ready,           1, 0);
        chk("rst_out_valid", out_valid,          0, 0);
        chk("rst_out_data",  (out_data === '0),  1, 0);
        chk("rst_out_sat",   out_sat,            0, 0);
        chk("rst_range_err", range_err,          0, 0);
        rst = 1'b0;
        step();

        // Constant-velocity case: exact results.
        send(v1, nw);
        wait_out(lat);
        chk("t1_latency", lat, 17, 0);
        chk_out("t1", 32'h0002_0000, 32'h0002_0000, 32'h0, 32'h0, 32'h0, 0, 1'b0, 1'b0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("t1_released", out_valid, 0, 0);
        chk("t1_idle",     in_ready,  1, 0);

        // w = 0.1: xi'=0.99833 xi_dot'=0.99500 eta'=0.04996 eta_dot'=0.09983.
        send(v2, nw);
        wait_out(lat);
        chk("t2_latency", lat, 17, 0);
        chk_out("t2", 32'd65427, 32'd65208, 32'd3274, 32'd6542, 32'h0000_1999, 4, 1'b0, 1'b0);

        // Stall 10 clocks with a competing input that must be ignored.
        snap = out_data;
        bad  = 0;
        for (int i = 0; i < 10; i++) begin
            in_data  = v4;
            in_valid = 1'b1;
            step();
            if (out_data !== snap || out_valid !== 1'b1 || in_ready !== 1'b0 || out_sat !== 1'b0)
                bad++;
        end
        in_valid = 1'b0;
        chk("t3_stall_unstable_cycles", bad, 0, 0);
        out_ready = 1'b1;
        step();
        chk("t3_released", out_valid, 0, 0);
        chk("t3_idle",     in_ready,  1, 0);

        // Back-to-back with out_ready held: accept-to-accept spacing.
        send(v2, nw);
        wait_out(lat);
        chk("tput_first_eta_dot", fld(out_data, 3), 32'd6542, 4);
        send(v1, nw);
        chk("tput_period", lat + nw + 1, 19, 0);
        wait_out(lat);
        chk_out("tput2", 32'h0002_0000, 32'h0002_0000, 32'h0, 32'h0, 32'h0, 0, 1'b0, 1'b0);

        // 32000 + 1000 overflows xi only.
        send(v4, nw);
        wait_out(lat);
        chk_out("t4", 32'h7FFF_FFFF, 32'h03E8_0000, 32'h0, 32'h0, 32'h0, 0, 1'b1, 1'b0);

        // Reset during op 7, then rerun the w = 0.1 vector.
        send(v2, nw);
        repeat (7) step();
        rst = 1'b1;
        #1;
        chk("t5_rst_out_valid", out_valid,         0, 0);
        chk("t5_rst_out_data",  (out_data === '0), 1, 0);
        chk("t5_rst_in_ready",  in_ready,          1, 0);
        step();
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (out_valid !== 1'b0) bad++;
        end
        chk("t5_no_stale_valid", bad, 0, 0);
        send(v2, nw);
        wait_out(lat);
        chk("t5_latency", lat, 17, 0);
        chk_out("t5", 32'd65427, 32'd65208, 32'd3274, 32'd6542, 32'h0000_1999, 4, 1'b0, 1'b0);

        // Range flag: 0.75 out of range, 0.4 within, MIN clamps and saturates.
        send(v6a, nw);
        wait_out(lat);
        chk("t6_latency",   lat,       17, 0);
        chk("t6_range_075", range_err, 1,  0);
        chk("t6_sat_075",   out_sat,   0,  0);
        send(v6b, nw);
        wait_out(lat);
        chk("t6_range_040", range_err, 0,  0);
        chk("t6_sat_040",   out_sat,   0,  0);
        send(vmin, nw);
        wait_out(lat);
        chk("t6_range_min", range_err, 1,  0);
        chk("t6_sat_min",   out_sat,   1,  0);
        chk("t6_w_min",     fld(out_data, 4), 32'sh8000_0000, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
